// File: rtl/field_extractor.sv
// field_extractor: takes one FIELD_SIZE-bit header field from a fixed byte offset of each packet.
// Define FIELD_EXTRACTOR_ETHERTYPE_FILTER_EN to emit only packets whose EtherType equals ETHERTYPE.
module field_extractor #(
  parameter int          FIELD_SIZE   = 16,
  parameter int          FIELD_OFFSET = 18,
  parameter int          DATA_BYTES   = 4,
  parameter logic [15:0] ETHERTYPE    = 16'h0800
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [8*DATA_BYTES-1:0] in_data,
  output logic                    valid,
  output logic [FIELD_SIZE-1:0]   field,
  output logic [15:0]             short_count
);

  localparam int FIELD_BYTES = FIELD_SIZE / 8;
  localparam int FIELD_END   = FIELD_OFFSET + FIELD_BYTES;
  localparam int BEAT_W      = $clog2(FIELD_OFFSET / DATA_BYTES + FIELD_BYTES) + 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'((FIELD_END - 1) / DATA_BYTES);
  localparam logic [BEAT_W-1:0] BEAT_SAT  = '1;

  if (FIELD_SIZE < 8 || FIELD_SIZE % 8 != 0) begin : g_bad_field_size
    $error("field_extractor: FIELD_SIZE must be a non-zero multiple of 8");
  end
  if (DATA_BYTES < 1 || (DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_bad_data_bytes
    $error("field_extractor: DATA_BYTES must be a power of 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SKIP
  } state_t;

  state_t                state;
  logic [BEAT_W-1:0]     beat_idx;
  logic [BEAT_W-1:0]     cur_beat;
  logic [FIELD_SIZE-1:0] asm_q;
  logic [FIELD_SIZE-1:0] asm_next;
  logic                  active;
  logic                  field_done;
  logic                  reject;

  function automatic int byte_pos(input logic [BEAT_W-1:0] beat, input int j);
    return int'(beat) * DATA_BYTES + j;
  endfunction

  // A sop beat always restarts at beat 0, whatever state the FSM is in.
  assign active     = in_valid & (in_sop | (state == COLLECT));
  assign cur_beat   = in_sop ? '0 : beat_idx;
  assign field_done = (cur_beat == LAST_BEAT);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    asm_next = asm_q;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (byte_pos(cur_beat, j) >= FIELD_OFFSET && byte_pos(cur_beat, j) < FIELD_END) begin
        asm_next[8*(FIELD_END - byte_pos(cur_beat, j)) - 1 -: 8] = in_data[8*(DATA_BYTES-j)-1 -: 8];
      end
    end
  end

  // NOTE: the assembly register has no reset; each byte is rewritten before it can reach field.
  always_ff @(posedge sys_clk) begin
    if (active) asm_q <= asm_next;
  end

`ifdef FIELD_EXTRACTOR_ETHERTYPE_FILTER_EN
  localparam logic [BEAT_W-1:0] ET_BEAT = BEAT_W'(13 / DATA_BYTES);

  if (FIELD_OFFSET < 14) begin : g_bad_offset
    $error("field_extractor: FIELD_OFFSET must be >= 14 with the EtherType filter");
  end

  logic [15:0] etype_q;
  logic [15:0] etype_next;

  always_comb begin
    etype_next = etype_q;
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (byte_pos(cur_beat, j) == 12 || byte_pos(cur_beat, j) == 13) begin
        etype_next[8*(14 - byte_pos(cur_beat, j)) - 1 -: 8] = in_data[8*(DATA_BYTES-j)-1 -: 8];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (active) etype_q <= etype_next;
  end

  // Judged on the beat carrying byte 13; this wins even if the field completes on the same beat.
  assign reject = (cur_beat == ET_BEAT) && (etype_next != ETHERTYPE);
`else
  logic unused_ethertype;
  assign unused_ethertype = ^ETHERTYPE;
  assign reject           = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat_idx    <= '0;
      valid       <= 1'b0;
      field       <= '0;
      short_count <= '0;
    end else begin
      valid <= 1'b0;
      if (active) begin
        beat_idx <= '0;
        if (reject) begin
          state <= in_eop ? IDLE : SKIP;
        end else if (field_done) begin
          valid <= 1'b1;
          field <= asm_next;
          state <= in_eop ? IDLE : SKIP;
        end else if (in_eop) begin
          if (short_count != 16'hFFFF) short_count <= short_count + 16'd1;
          state <= IDLE;
        end else begin
          state    <= COLLECT;
          beat_idx <= (cur_beat == BEAT_SAT) ? cur_beat : cur_beat + 1'b1;
        end
      end else if (in_valid && in_eop && state == SKIP) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_field_extractor.sv
// Scoreboard bench for field_extractor: directed packets queue their expected pulse; monitors compare.
`timescale 1ns/1ps
module tb_field_extractor;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [15:0] val;
    int          cyc;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid, in_sop, in_eop;
  logic [31:0] in_data;
  logic        valid;
  logic [15:0] field, short_count;
  logic        b_in_valid, b_in_sop, b_in_eop;
  logic [31:0] b_in_data;
  logic        b_valid;
  logic [15:0] b_field, b_short_count;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_short = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  field_extractor dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_data(in_data), .valid(valid), .field(field),
    .short_count(short_count)
  );

  // Second instance with the field straddling beats 4/5.
  field_extractor #(.FIELD_OFFSET(19)) dut19 (
    .sys_clk(sys_clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_sop(b_in_sop),
    .in_eop(b_in_eop), .in_data(b_in_data), .valid(b_valid), .field(b_field),
    .short_count(b_short_count)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (valid === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_valid", 32'(valid), 32'd0);
      else begin
        ea = q_a.pop_front();
        check("a_field", 32'(field), 32'(ea.val));
        check("a_pulse_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end
  end

  always @(negedge sys_clk) begin
    if (b_valid === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_valid", 32'(b_valid), 32'd0);
      else begin
        eb = q_b.pop_front();
        check("b_field", 32'(b_field), 32'(eb.val));
        check("b_pulse_cycle", 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  task automatic drive(input int sel, input logic v, input logic s, input logic e,
                       input logic [31:0] d);
    if (sel == 0) begin
      in_valid = v; in_sop = s; in_eop = e; in_data = d;
    end else begin
      b_in_valid = v; b_in_sop = s; b_in_eop = e; b_in_data = d;
    end
  endtask

  task automatic idle(input int n);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0);
    if (n > 0) begin
      repeat (n) @(posedge sys_clk);
      #1;
    end
  endtask

  function automatic bytes_t make_pkt(input int len, input logic [15:0] et, input int off,
                                      input logic [15:0] fld);
    bytes_t p;
    for (int i = 0; i < len; i++) p.push_back(8'(i) ^ 8'hC3);
    if (len > 13) begin
      p[12] = et[15:8];
      p[13] = et[7:0];
    end
    if (len > off + 1) begin
      p[off]   = fld[15:8];
      p[off+1] = fld[7:0];
    end
    return p;
  endfunction

  // exp_beat < 0 means the packet must not pulse; a gap of gap_len idle cycles follows gap_beat.
  task automatic send_packet(input int sel, input bytes_t pkt, input bit with_sop,
                             input bit with_eop, input int exp_beat, input logic [15:0] exp_val,
                             input int gap_beat = -1, input int gap_len = 0);
    int          nbeats;
    logic [31:0] d;
    exp_t        e;
    nbeats = (pkt.size() + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      d = '0;
      for (int j = 0; j < 4; j++)
        if (b * 4 + j < pkt.size()) d[8*(4-j)-1 -: 8] = pkt[b*4+j];
      drive(sel, 1'b1, with_sop && b == 0, with_eop && b == nbeats - 1, d);
      @(posedge sys_clk);
      #1;
      if (b == exp_beat) begin
        e.val = exp_val;
        e.cyc = cyc;
        if (sel == 0) q_a.push_back(e);
        else q_b.push_back(e);
      end
      if (b == gap_beat) idle(gap_len);
    end
  endtask

  initial begin
    idle(0);
    reset_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_field", 32'(field), 32'd0);
    check("reset_short_count", 32'(short_count), 32'd0);
    reset_n = 1'b1;
    idle(1);

    // 64-byte packet, field 0xABCD completes on beat 4.
    send_packet(0, make_pkt(64, 16'h0800, 18, 16'hABCD), 1, 1, 4, 16'hABCD);
    idle(5);
    check("field_hold", 32'(field), 32'h0000_ABCD);

    // Straddling field with a 3-cycle bubble between beats 4 and 5.
    send_packet(1, make_pkt(64, 16'h0800, 19, 16'h1234), 1, 1, 5, 16'h1234, 4, 3);
    idle(3);

    // 16-byte packet ends before the field.
    send_packet(0, make_pkt(16, 16'h0800, 18, 16'hFFFF), 1, 1, -1, 16'h0);
    exp_short++;
    idle(2);
    check("short_after_16B", 32'(short_count), 32'(exp_short));

    // 20-byte packet: field completes on the eop beat.
    send_packet(0, make_pkt(20, 16'h0800, 18, 16'h2020), 1, 1, 4, 16'h2020);
    idle(2);
    check("short_after_20B", 32'(short_count), 32'(exp_short));

    // Packet abandoned by sop on its beat 2; the new packet carries 0x5555.
    send_packet(0, make_pkt(8, 16'h0800, 18, 16'h9999), 1, 0, -1, 16'h0);
    send_packet(0, make_pkt(64, 16'h0800, 18, 16'h5555), 1, 1, 4, 16'h5555);
    idle(2);
    check("short_after_abandon", 32'(short_count), 32'(exp_short));

    // Beats without a preceding sop are discarded.
    send_packet(0, make_pkt(24, 16'h0800, 18, 16'hBEEF), 0, 1, -1, 16'h0);
    idle(2);
    check("field_after_stray", 32'(field), 32'h0000_5555);
    check("short_after_stray", 32'(short_count), 32'(exp_short));

    // Non-IPv4 EtherType followed back-to-back by an IPv4 packet.
`ifdef FIELD_EXTRACTOR_ETHERTYPE_FILTER_EN
    send_packet(0, make_pkt(32, 16'h86DD, 18, 16'h7777), 1, 1, -1, 16'h0);
`else
    send_packet(0, make_pkt(32, 16'h86DD, 18, 16'h7777), 1, 1, 4, 16'h7777);
`endif
    send_packet(0, make_pkt(32, 16'h0800, 18, 16'h0001), 1, 1, 4, 16'h0001);
    idle(2);
    check("field_after_ethertype", 32'(field), 32'h0000_0001);
    check("short_after_ethertype", 32'(short_count), 32'(exp_short));

    // Ten back-to-back 32-byte packets, fields 1..10.
    for (int k = 1; k <= 10; k++)
      send_packet(0, make_pkt(32, 16'h0800, 18, 16'(k)), 1, 1, 4, 16'(k));
    idle(3);
    check("b2b_all_pulsed", 32'(q_a.size()), 32'd0);

    // Single-beat packets every cycle until short_count saturates.
    for (int k = 0; k < 65536; k++) begin
      drive(0, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5);
      @(posedge sys_clk);
      #1;
      if (exp_short < 65535) exp_short++;
      if (k == 9) check("short_single_beat_rate", 32'(short_count), 32'(exp_short));
    end
    idle(2);
    check("short_saturated", 32'(short_count), 32'h0000_FFFF);

    // Reset asserted mid-packet clears everything at once.
    send_packet(0, make_pkt(12, 16'h0800, 18, 16'h0), 1, 0, -1, 16'h0);
    reset_n = 1'b0;
    idle(0);
    #2;
    check("midrst_short_count", 32'(short_count), 32'd0);
    check("midrst_field", 32'(field), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    exp_short = 0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send_packet(0, make_pkt(20, 16'h0800, 18, 16'hDEAD), 0, 1, -1, 16'h0);
    send_packet(0, make_pkt(24, 16'h0800, 18, 16'h4242), 1, 1, 4, 16'h4242);
    idle(3);
    check("post_reset_field", 32'(field), 32'h0000_4242);
    check("post_reset_short", 32'(short_count), 32'(exp_short));
    check("a_pending_pulses", 32'(q_a.size()), 32'd0);
    check("b_pending_pulses", 32'(q_b.size()), 32'd0);
    check("b_short_count", 32'(b_short_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
